pixel_write_buffer: RTL and testbench

- Downstream stage of the board/win-screen drawing engine, which emits one (x, y, colour) pixel per cycle while drawing.
- Buffers the stream in a small FIFO, clips pixels outside the 160x120 screen, and converts (x, y) to a linear frame-memory address y*160+x.
- Drives a single-port frame-memory write interface that may stall; back-pressures the drawing engine via in_ready.

---
 rtl/pixel_write_buffer.sv | 89 ++++++++
 tb/tb_pixel_write_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_buffer.sv
// Pixel FIFO between the drawing engine and frame memory.
// Clips off-screen pixels and turns (x, y) into a linear address.
module pixel_write_buffer #(
  parameter int DEPTH = 8,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120,
  parameter int CW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_x,
  input  logic [6:0]    in_y,
  input  logic [CW-1:0] in_colour,
  output logic          in_ready,
  input  logic          mem_busy,
  output logic          wr_en,
  output logic [14:0]   wr_addr,
  output logic [CW-1:0] wr_data,
  output logic          frame_done,
  output logic [7:0]    clip_count,
  output logic [3:0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] FULL  = PW'(DEPTH);
  localparam logic [PW-1:0] ONE   = PW'(1);
  localparam logic [7:0]    XMAX  = 8'(SCR_W);
  localparam logic [6:0]    YMAX  = 7'(SCR_H);
  localparam logic [14:0]   W15   = 15'(SCR_W);
  localparam logic [14:0]   LAST  = 15'(SCR_W * SCR_H - 1);

  logic [14:0]   addr_q [DEPTH];
  logic [CW-1:0] col_q  [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] cnt;
  logic          take;
  logic          in_range;
  logic          push;
  logic          pop;
  logic [14:0]   push_addr;
  logic [14:0]   head_addr;

  // Extra pointer bit lets the difference reach DEPTH without ambiguity
  assign cnt       = wptr - rptr;
  assign level     = 4'(cnt);
  assign in_ready  = (cnt < FULL);
  assign take      = in_valid && in_ready;
  assign in_range  = (in_x < XMAX) && (in_y < YMAX);
  assign push      = take && in_range;
  assign pop       = (cnt != '0) && !mem_busy;
  assign push_addr = 15'(in_y) * W15 + 15'(in_x);
  assign head_addr = addr_q[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr[AW-1:0]] <= push_addr;
      col_q[wptr[AW-1:0]]  <= in_colour;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      clip_count <= '0;
    end else begin
      if (push) wptr <= wptr + ONE;
      if (pop) begin
        rptr    <= rptr + ONE;
        wr_addr <= head_addr;
        wr_data <= col_q[rptr[AW-1:0]];
      end
      wr_en      <= pop;
      frame_done <= pop && (head_addr == LAST);
      if (take && !in_range && (clip_count != 8'hFF))
        clip_count <= clip_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed bench for pixel_write_buffer with a write scoreboard.
// Accepted in-range pixels are queued and matched against writes.
module tb_pixel_write_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_x = '0;
  logic [6:0]  in_y = '0;
  logic [8:0]  in_colour = '0;
  logic        in_ready;
  logic        mem_busy = 1'b0;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [8:0]  wr_data;
  logic        frame_done;
  logic [7:0]  clip_count;
  logic [3:0]  level;

  int tests = 0;
  int fails = 0;
  int stalls = 0;
  int fd_count = 0;
  int exp_clip = 0;
  logic last_acc = 1'b0;
  logic last_busy = 1'b0;
  logic tog = 1'b0;
  logic [23:0] sb[$];

  pixel_write_buffer dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_x(in_x),
    .in_y(in_y),
    .in_colour(in_colour),
    .in_ready(in_ready),
    .mem_busy(mem_busy),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_done(frame_done),
    .clip_count(clip_count),
    .level(level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) last_busy <= mem_busy;

  task automatic fail(string tag, longint got, longint exp);
    fails++;
    $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    logic [23:0] e;
    if (last_busy) begin
      tests++;
      if (wr_en !== 1'b0) fail("busy_no_write", wr_en, 0);
    end
    if (wr_en === 1'b1) begin
      if (frame_done === 1'b1) fd_count++;
      tests++;
      if (sb.size() == 0) fail("write_expected", 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (wr_addr !== e[23:9])
          fail("wr_addr", wr_addr, e[23:9]);
        tests++;
        if (wr_data !== e[8:0])
          fail("wr_data", wr_data, e[8:0]);
        tests++;
        if (frame_done !== (e[23:9] == 15'd19199))
          fail("frame_done", frame_done,
               e[23:9] == 15'd19199);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    logic rdy;
    logic inr;
    if (tog) mem_busy = ~mem_busy;
    rdy = in_ready;
    @(posedge clk);
    last_acc = in_valid && rdy && !reset;
    inr = (in_x < 8'd160) && (in_y < 7'd120);
    if (reset) begin
      sb.delete();
      exp_clip = 0;
    end else if (last_acc) begin
      if (inr) sb.push_back({15'(in_y * 160 + in_x), in_colour});
      else if (exp_clip != 255) exp_clip++;
    end
    @(negedge clk);
  endtask

  task automatic setpix(int x, int y, int c);
    in_valid = 1'b1;
    in_x = 8'(x);
    in_y = 7'(y);
    in_colour = 9'(c);
  endtask

  task automatic send(int x, int y, int c);
    setpix(x, y, c);
    for (int t = 0; t < 200; t++) begin
      cycle();
      if (last_acc) break;
      stalls++;
    end
    if (!last_acc) begin
      tests++;
      fail("send_timeout", last_acc, 1);
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (sb.size() == 0) break;
      cycle();
    end
    repeat (3) cycle();
    tests++;
    if (sb.size() != 0) fail("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int k;
    int acc;
    @(negedge clk);
    cycle();
    reset = 1'b0;
    tests++;
    if (level !== 4'd0) fail("rst_level", level, 0);
    tests++;
    if (in_ready !== 1'b1) fail("rst_ready", in_ready, 1);
    tests++;
    if (wr_en !== 1'b0) fail("rst_wr_en", wr_en, 0);
    tests++;
    if (wr_addr !== 15'd0) fail("rst_wr_addr", wr_addr, 0);
    tests++;
    if (wr_data !== 9'd0) fail("rst_wr_data", wr_data, 0);
    tests++;
    if (frame_done !== 1'b0)
      fail("rst_frame_done", frame_done, 0);
    tests++;
    if (clip_count !== 8'd0) fail("rst_clip", clip_count, 0);

    stalls = 0;
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        send(x, y, (x ^ (y * 3)) & 511);
        if (y == 0 && x == 0) begin
          tests++;
          if (wr_en !== 1'b0) fail("lat_n1", wr_en, 0);
        end
        if (y == 0 && x == 1) begin
          tests++;
          if (wr_en !== 1'b1) fail("lat_n2_en", wr_en, 1);
          tests++;
          if (wr_addr !== 15'd0)
            fail("lat_n2_addr", wr_addr, 0);
        end
      end
    end
    drain();
    tests++;
    if (stalls != 0) fail("frame_stalls", stalls, 0);
    tests++;
    if (fd_count != 1) fail("frame_done_count", fd_count, 1);

    mem_busy = 1'b1;
    k = 0;
    acc = 0;
    setpix(10 + k, 50, 100 + k);
    for (int t = 0; t < 12; t++) begin
      cycle();
      if (last_acc) begin
        acc++;
        k++;
        setpix(10 + k, 50, 100 + k);
      end
    end
    tests++;
    if (acc != 8) fail("bp_accepted", acc, 8);
    tests++;
    if (level !== 4'd8) fail("bp_level", level, 8);
    tests++;
    if (in_ready !== 1'b0) fail("bp_ready", in_ready, 0);
    mem_busy = 1'b0;
    for (int t = 0; t < 8; t++) begin
      cycle();
      tests++;
      if (wr_en !== 1'b1) fail("bp_consec", wr_en, 1);
      if (last_acc) begin
        k++;
        if (k < 10) setpix(10 + k, 50, 100 + k);
        else in_valid = 1'b0;
      end
    end
    while (k < 10) begin
      send(10 + k, 50, 100 + k);
      k++;
    end
    drain();

    send(160, 0, 1);
    send(5, 3, 2);
    send(0, 120, 3);
    send(6, 3, 4);
    send(255, 127, 5);
    drain();
    tests++;
    if (clip_count !== 8'd3) fail("clip_3", clip_count, 3);
    tests++;
    if (clip_count !== 8'(exp_clip))
      fail("clip_model", clip_count, exp_clip);
    for (int i = 0; i < 300; i++)
      send(160 + (i % 96), i % 128, i);
    drain();
    tests++;
    if (clip_count !== 8'd255)
      fail("clip_sat", clip_count, 255);

    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) send(i, 7, 200 + i);
    tests++;
    if (level !== 4'd4) fail("sim_level0", level, 4);
    mem_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(20 + i, 8, 300 + i);
      tests++;
      if (level !== 4'd4) fail("sim_level", level, 4);
      tests++;
      if (wr_en !== 1'b1) fail("sim_wr_en", wr_en, 1);
    end
    drain();

    mem_busy = 1'b1;
    for (int i = 0; i < 6; i++) send(40 + i, 9, 400 + i);
    tests++;
    if (level !== 4'd6) fail("mid_level6", level, 6);
    in_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    tests++;
    if (level !== 4'd0) fail("mid_level", level, 0);
    tests++;
    if (wr_en !== 1'b0) fail("mid_wr_en", wr_en, 0);
    tests++;
    if (wr_addr !== 15'd0) fail("mid_wr_addr", wr_addr, 0);
    tests++;
    if (clip_count !== 8'd0) fail("mid_clip", clip_count, 0);
    tests++;
    if (in_ready !== 1'b1) fail("mid_ready", in_ready, 1);
    mem_busy = 1'b0;
    drain();

    tog = 1'b1;
    for (int i = 0; i < 50; i++)
      send(i * 3, 60 + (i % 5), 500 - i);
    drain();
    tog = 1'b0;
    mem_busy = 1'b0;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
